fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Produces the forwarding selects (forward_a, forward_b) consumed by the EX stage, plus the load-use stall and bubble controls for the 5-stage pipeline.
- Keeps its own pipelined record of in-flight destinations (EX, MEM, WB) fed from the ID stage.
- Forward selects are registered so they are valid for the whole cycle the consuming instruction sits in EX.

Parameters:
- CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID holds a real instruction
- id_rs  input  5  rs field of ID instruction
- id_rt  input  5  rt field of ID instruction
- id_use_rs  input  1  ID instruction reads rs
- id_use_rt  input  1  ID instruction reads rt (register operand, incl. store data)
- id_dst  input  5  resolved destination (rt/rd/31) of ID instruction
- id_regwrite  input  1  ID instruction writes register file
- id_memread  input  1  ID instruction is a load
- flush  input  1  branch/jump taken; kill ID instruction
- hold  input  1  global freeze (memory wait)
- forward_a  output  2  EX rs operand select: 00 regfile, 01 wb_data, 10 ex_mem_data
- forward_b  output  2  EX rt operand select, same encoding
- stall  output  1  hold PC and IF/ID this cycle
- bubble  output  1  insert NOP into ID/EX this cycle
- stall_cnt  output  CNT_W  saturating count of load-use stall cycles

Behaviour:
- State: three slots ex_q, mem_q, wb_q, each {valid, dst[4:0], regwrite, memread}; registered forward_a/forward_b; stall_cnt.
- Reset (async, rst_n low): all slot valid=0, forward_a=forward_b=00, stall_cnt=0. stall and bubble are combinational and therefore read 0 with slots invalid. Applies immediately, including mid-stall.
- Producer match: slot S matches reg r iff S.valid && S.regwrite && S.dst==r && r!=0. Register 0 never forwards.
- stall = id_valid && ex_q.memread && ((id_use_rs && ex_q matches id_rs) || (id_use_rt && ex_q matches id_rt)) && !flush. Combinational. Load-use costs exactly 1 cycle.
- bubble = stall || flush.
- Next forward_a (computed in ID, registered at edge):
  - 10 if id_use_rs && ex_q matches id_rs;
  - else 01 if id_use_rs && mem_q matches id_rs;
  - else 00.
  - EX-slot match has priority over MEM-slot match.
  - forward_b: same rules using id_rt and id_use_rt.
- wb_q match needs no forward: the register file writes in the first half-cycle and reads in the second.
- Edge update when hold=0:
  - wb_q<=mem_q; mem_q<=ex_q.
  - ex_q<={id_valid,...} if !bubble, else valid=0.
  - forwards <= next values if !bubble, else 00.
- Edge update when hold=1: every register keeps its value. stall_cnt does not count. stall/bubble are still computed but have no effect on state.
- stall_cnt increments by 1 on each edge with stall=1 && hold=0. Saturates at all-ones.
- flush together with a load-use condition: flush wins (stall=0, bubble=1).
- Latency: forward selects are valid one cycle after the instruction is in ID, i.e. during its EX cycle.

Decomposition:
- Shared package:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_EXMEM=2'b10
  - slot record type {valid, dst, regwrite, memread}
  - REG_ZERO=5'd0
- One natural sub-module: fwd_match (combinational: slot record + reg + use → match bit), instantiated four times.

Test Plan:
- EX→EX: add $3 (id_dst=3, regwrite) then sub reads rs=$3 next cycle → forward_a=10 during sub's EX cycle; stall stays 0.
- MEM→EX: add $5, one unrelated instr, then or rt=$5 → forward_b=01 during or's EX; with two gaps → 00.
- Priority: addi $4, addi $4, add rs=$4 rt=$4 → forward_a=forward_b=10.
- Load-use: lw $7 then add rs=$7 → stall=1 and bubble=1 for exactly 1 cycle; add's EX sees forward_a=01; stall_cnt increments 0→1.
- $0 and flush: producer dst=0 then consumer rs=0 → forward_a=00. Load-use with flush=1 → stall=0, bubble=1, stall_cnt unchanged.
- Hold/reset:
  - hold=1 for 3 cycles during a pending forward → forward_a holds its value and slots are frozen.
  - rst_n pulsed low mid-stall → stall=0, forwards=00, stall_cnt=0 immediately.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared types and constants for the forwarding/hazard unit
// Contents: forward select encodings, register-zero constant, in-flight slot record.
package fwd_hazard_unit_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       regwrite;
        logic       memread;
    } slot_t;

endpackage

// File: rtl/fwd_hazard_unit_fwd_match.sv
// rtl/fwd_hazard_unit_fwd_match.sv - producer match of one in-flight slot against one source register
// Ports:
//   slot    in  in-flight destination record
//   reg_num in  source register number read by the ID instruction
//   use_reg in  ID instruction actually reads reg_num
//   match   out slot produces the value that reg_num needs
module fwd_match
    import fwd_hazard_unit_pkg::*;
(
    input  slot_t      slot,
    input  logic [4:0] reg_num,
    input  logic       use_reg,
    output logic       match
);

    // The load flag is not part of the match; the stall logic reads it directly.
    logic unused_memread;
    assign unused_memread = slot.memread;

    // Register 0 is hardwired, so it never has a producer.
    assign match = use_reg && slot.valid && slot.regwrite &&
                   (slot.dst == reg_num) && (reg_num != REG_ZERO);

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX operand forwarding selects and load-use stall/bubble control
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   id_*                 decoded fields of the instruction currently in ID
//   flush                taken branch/jump kills the ID instruction
//   hold                 global freeze; all state keeps its value
//   forward_a/forward_b  registered EX operand selects (00 regfile, 01 wb, 10 ex/mem)
//   stall, bubble        combinational pipeline controls for this cycle
//   stall_cnt            saturating count of load-use stall cycles
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       id_dst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    input  logic             hold,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_t ex_q;
    slot_t mem_q;
    slot_t wb_q;

    logic ex_rs_match;
    logic ex_rt_match;
    logic mem_rs_match;
    logic mem_rt_match;

    logic [1:0] next_fwd_a;
    logic [1:0] next_fwd_b;

    // The WB slot never needs a bypass: the register file writes in the first
    // half-cycle and reads in the second. It is tracked only to mirror the pipe.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    fwd_match u_ex_rs  (.slot(ex_q),  .reg_num(id_rs), .use_reg(id_use_rs), .match(ex_rs_match));
    fwd_match u_ex_rt  (.slot(ex_q),  .reg_num(id_rt), .use_reg(id_use_rt), .match(ex_rt_match));
    fwd_match u_mem_rs (.slot(mem_q), .reg_num(id_rs), .use_reg(id_use_rs), .match(mem_rs_match));
    fwd_match u_mem_rt (.slot(mem_q), .reg_num(id_rt), .use_reg(id_use_rt), .match(mem_rt_match));

    // A load in EX cannot supply its data until after MEM, so a dependent ID
    // instruction waits one cycle. A flush kills the consumer, so no stall.
    assign stall  = id_valid && ex_q.memread && (ex_rs_match || ex_rt_match) && !flush;
    assign bubble = stall || flush;

    // The youngest producer (EX slot) wins over the older one (MEM slot).
    always_comb begin
        next_fwd_a = FWD_REG;
        next_fwd_b = FWD_REG;
        if (ex_rs_match) begin
            next_fwd_a = FWD_EXMEM;
        end else if (mem_rs_match) begin
            next_fwd_a = FWD_WB;
        end
        if (ex_rt_match) begin
            next_fwd_b = FWD_EXMEM;
        end else if (mem_rt_match) begin
            next_fwd_b = FWD_WB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            forward_a <= FWD_REG;
            forward_b <= FWD_REG;
            stall_cnt <= '0;
        end else if (!hold) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (bubble) begin
                ex_q      <= '0;
                forward_a <= FWD_REG;
                forward_b <= FWD_REG;
            end else begin
                ex_q      <= '{valid: id_valid, dst: id_dst,
                               regwrite: id_regwrite, memread: id_memread};
                forward_a <= next_fwd_a;
                forward_b <= next_fwd_b;
            end
            if (stall && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard bench for fwd_hazard_unit with a reference pipeline model
module tb_fwd_hazard_unit;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs = '0;
    logic [4:0]       id_rt = '0;
    logic             id_use_rs = 1'b0;
    logic             id_use_rt = 1'b0;
    logic [4:0]       id_dst = '0;
    logic             id_regwrite = 1'b0;
    logic             id_memread = 1'b0;
    logic             flush = 1'b0;
    logic             hold = 1'b0;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] stall_cnt;

    fwd_hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .hold(hold),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall(stall), .bubble(bubble), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       urs;
        bit       urt;
        bit [4:0] dst;
        bit       rw;
        bit       mr;
    } ins_t;

    typedef struct {
        bit       st;
        bit       bb;
        bit [1:0] fa;
        bit [1:0] fb;
        int       cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the instructions that entered EX, youngest first
    // (index 0 is in EX now, index 1 is in MEM now).
    ins_t     hist[$];
    bit [1:0] m_fa;
    bit [1:0] m_fb;
    int       m_cnt;

    function automatic ins_t mk(bit v, bit [4:0] rs, bit [4:0] rt, bit urs, bit urt,
                                bit [4:0] dst, bit rw, bit mr);
        ins_t i;
        i.v = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
        i.dst = dst; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    function automatic ins_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic bit produces(ins_t p, bit [4:0] r);
        return p.v && p.rw && (p.dst == r) && (r != 0);
    endfunction

    // Youngest in-flight producer decides the source; WB-age producers need nothing.
    function automatic bit [1:0] source_for(bit used, bit [4:0] r);
        if (!used) return 2'd0;
        if (produces(hist[0], r)) return 2'd2;
        if (produces(hist[1], r)) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(nop());
        hist.push_back(nop());
        m_fa  = 0;
        m_fb  = 0;
        m_cnt = 0;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input ins_t i, input bit fl, input bit hd, input bit rstn);
        bit       st;
        bit       bb;
        bit [1:0] nfa;
        bit [1:0] nfb;
        exp_t     e;
        id_valid = i.v; id_rs = i.rs; id_rt = i.rt;
        id_use_rs = i.urs; id_use_rt = i.urt;
        id_dst = i.dst; id_regwrite = i.rw; id_memread = i.mr;
        flush = fl; hold = hd;
        #2;
        rst_n = rstn;
        if (!rstn) model_reset();
        st = i.v && hist[0].mr &&
             ((i.urs && produces(hist[0], i.rs)) || (i.urt && produces(hist[0], i.rt))) && !fl;
        bb = st || fl;
        nfa = source_for(i.urs, i.rs);
        nfb = source_for(i.urt, i.rt);
        e.st = st; e.bb = bb; e.fa = m_fa; e.fb = m_fb; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!rstn) begin
            model_reset();
        end else if (!hd) begin
            hist.push_front(bb ? nop() : i);
            void'(hist.pop_back());
            m_fa = bb ? 2'd0 : nfa;
            m_fb = bb ? 2'd0 : nfb;
            if (st && m_cnt < CMAX) m_cnt++;
        end
    endtask

    // Monitor: compares the DUT against the oldest expectation mid-cycle.
    initial begin
        exp_t e;
        int   cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 5;
                if (stall !== e.st) begin
                    errors++;
                    $display("FAIL stall cyc=%0d actual=%0d expected=%0d", cyc, stall, e.st);
                end
                if (bubble !== e.bb) begin
                    errors++;
                    $display("FAIL bubble cyc=%0d actual=%0d expected=%0d", cyc, bubble, e.bb);
                end
                if (forward_a !== e.fa) begin
                    errors++;
                    $display("FAIL forward_a cyc=%0d actual=%0d expected=%0d", cyc, forward_a, e.fa);
                end
                if (forward_b !== e.fb) begin
                    errors++;
                    $display("FAIL forward_b cyc=%0d actual=%0d expected=%0d", cyc, forward_b, e.fb);
                end
                if (int'(stall_cnt) !== e.cnt) begin
                    errors++;
                    $display("FAIL stall_cnt cyc=%0d actual=%0d expected=%0d", cyc, stall_cnt, e.cnt);
                end
                cyc++;
            end
        end
    end

    initial begin
        ins_t add3, sub3, add5, other, or5, addi4, use44, lw7, use7, p0, use0;
        model_reset();
        add3  = mk(1, 1, 2, 1, 1, 3, 1, 0);
        sub3  = mk(1, 3, 0, 1, 0, 9, 1, 0);
        add5  = mk(1, 1, 2, 1, 1, 5, 1, 0);
        other = mk(1, 1, 2, 1, 1, 8, 1, 0);
        or5   = mk(1, 1, 5, 1, 1, 6, 1, 0);
        addi4 = mk(1, 1, 0, 1, 0, 4, 1, 0);
        use44 = mk(1, 4, 4, 1, 1, 10, 1, 0);
        lw7   = mk(1, 1, 0, 1, 0, 7, 1, 1);
        use7  = mk(1, 7, 2, 1, 1, 11, 1, 0);
        p0    = mk(1, 1, 0, 1, 0, 0, 1, 0);
        use0  = mk(1, 0, 0, 1, 1, 12, 1, 0);

        @(posedge clk);
        #1;
        // Reset state, with a load-use pattern on the inputs.
        cycle(lw7, 0, 0, 0);
        cycle(use7, 0, 0, 0);
        cycle(nop(), 0, 0, 1);

        // EX->EX forward
        cycle(add3, 0, 0, 1); cycle(sub3, 0, 0, 1); cycle(nop(), 0, 0, 1);
        // MEM->EX forward, then two gaps
        cycle(add5, 0, 0, 1); cycle(other, 0, 0, 1); cycle(or5, 0, 0, 1); cycle(nop(), 0, 0, 1);
        cycle(add5, 0, 0, 1); cycle(other, 0, 0, 1); cycle(other, 0, 0, 1);
        cycle(or5, 0, 0, 1); cycle(nop(), 0, 0, 1);
        // EX priority over MEM
        cycle(addi4, 0, 0, 1); cycle(addi4, 0, 0, 1); cycle(use44, 0, 0, 1); cycle(nop(), 0, 0, 1);
        // Load-use: one stall, consumer re-presented, then forwards from WB path
        cycle(lw7, 0, 0, 1); cycle(use7, 0, 0, 1); cycle(use7, 0, 0, 1); cycle(nop(), 0, 0, 1);
        // Register zero never forwards
        cycle(p0, 0, 0, 1); cycle(use0, 0, 0, 1); cycle(nop(), 0, 0, 1);
        // Flush beats load-use
        cycle(lw7, 0, 0, 1); cycle(use7, 1, 0, 1); cycle(nop(), 0, 0, 1);
        // Hold freezes a pending forward for three cycles
        cycle(add3, 0, 0, 1); cycle(sub3, 0, 0, 1);
        for (int k = 0; k < 3; k++) cycle(other, 0, 1, 1);
        cycle(nop(), 0, 0, 1); cycle(nop(), 0, 0, 1);
        // Counter saturation
        for (int k = 0; k < CMAX + 4; k++) begin
            cycle(lw7, 0, 0, 1);
            cycle(use7, 0, 0, 1);
        end
        // Reset mid-stall
        cycle(lw7, 0, 0, 1); cycle(use7, 0, 0, 0); cycle(nop(), 0, 0, 1); cycle(nop(), 0, 0, 1);

        // Randomized traffic over a small register set to provoke hazards
        for (int k = 0; k < 600; k++) begin
            ins_t r;
            r = mk($urandom_range(9, 0) != 0, 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                   1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                   5'($urandom_range(3, 0)), $urandom_range(4, 0) != 0,
                   $urandom_range(2, 0) == 0);
            cycle(r, $urandom_range(9, 0) == 0, $urandom_range(9, 0) == 0,
                  $urandom_range(99, 0) != 0);
        end

        cycle(nop(), 0, 0, 1);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
